// File: rtl/replacer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : replacer_pkg
// Description : Shared geometry and tree-PLRU helpers for the replacer.
// Revision    : 1.0 - initial release
// ============================================================================
package replacer_pkg;

    localparam int NSET_DEFAULT = 32;
    localparam int NWAY_DEFAULT = 8;
    localparam int IDX_W        = $clog2(NSET_DEFAULT);
    localparam int WAY_W        = $clog2(NWAY_DEFAULT);
    localparam int NODE_CNT     = NWAY_DEFAULT - 1;

    // Per-set state. The filled bits sit above the tree bits.
    typedef struct packed {
        logic [NWAY_DEFAULT-1:0] filled;
        logic [NODE_CNT-1:0]     plru;
    } set_state_t;

    // Tree walk: a 0 node points at the lower half, a 1 node at the upper half.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NODE_CNT-1:0] plru);
        logic b0;
        logic b1;
        logic b2;
        b0 = plru[0];
        b1 = b0 ? plru[2] : plru[1];
        case ({b0, b1})
            2'b00:   b2 = plru[3];
            2'b01:   b2 = plru[4];
            2'b10:   b2 = plru[5];
            default: b2 = plru[6];
        endcase
        return {b0, b1, b2};
    endfunction

    // Point every node on the path to `w` away from it.
    function automatic logic [NODE_CNT-1:0] plru_touch(input logic [NODE_CNT-1:0] plru,
                                                       input logic [WAY_W-1:0]    w);
        logic [NODE_CNT-1:0] p;
        p    = plru;
        p[0] = ~w[2];
        if (w[2]) p[2] = ~w[1];
        else      p[1] = ~w[1];
        case (w[2:1])
            2'b00:   p[3] = ~w[0];
            2'b01:   p[4] = ~w[0];
            2'b10:   p[5] = ~w[0];
            default: p[6] = ~w[0];
        endcase
        return p;
    endfunction

    // Lowest-numbered way whose filled bit is clear.
    function automatic logic [WAY_W-1:0] first_unfilled(input logic [NWAY_DEFAULT-1:0] filled);
        logic [WAY_W-1:0] v;
        v = '0;
        for (int i = NWAY_DEFAULT - 1; i >= 0; i--) begin
            if (!filled[i]) v = WAY_W'(i);
        end
        return v;
    endfunction

endpackage : replacer_pkg
`default_nettype wire

// File: rtl/replacer_reg.sv
`default_nettype none
// ============================================================================
// Module      : Reg
// Description : Generic write-enabled register with synchronous reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    always_ff @(posedge clock) begin
        if (reset) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule : Reg
`default_nettype wire

// File: rtl/replacer.sv
`default_nettype none
// ============================================================================
// Module      : replacer
// Description : Per-set tree-PLRU victim selector with fill tracking (8-way).
// Revision    : 1.0 - initial release
// ============================================================================
module replacer
    import replacer_pkg::*;
#(
    parameter int NSET = NSET_DEFAULT,
    parameter int NWAY = NWAY_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [$clog2(NSET)-1:0] idx,
    input  logic [$clog2(NWAY)-1:0] way,
    input  logic                    access,
    input  logic                    invalid,
    output logic [$clog2(NWAY)-1:0] rway_o
);

    localparam int c_IDX_W   = $clog2(NSET);
    localparam int c_STATE_W = $bits(set_state_t);

    logic [c_STATE_W-1:0] w_state [NSET];
    set_state_t           w_cur;
    set_state_t           w_next;
    logic                 w_strobe;

    assign w_strobe = access | invalid;
    assign w_cur    = set_state_t'(w_state[idx]);

    // Unfilled ways are always consumed before the tree is consulted.
    assign rway_o = (&w_cur.filled) ? plru_victim(w_cur.plru)
                                    : first_unfilled(w_cur.filled);

    // The access update is applied last so it overrides an eviction of the same way.
    always_comb begin
        w_next = w_cur;
        if (invalid) begin
            w_next.filled[rway_o] = 1'b0;
        end
        if (access) begin
            w_next.filled[way] = 1'b1;
            w_next.plru        = plru_touch(w_cur.plru, way);
        end
    end

    // Every set shares the same din; only the addressed set loads it.
    generate
        for (genvar g = 0; g < NSET; g++) begin : g_set
            logic w_wen;
            assign w_wen = w_strobe & (idx == c_IDX_W'(g));

            Reg #(
                .WIDTH     (c_STATE_W),
                .RESET_VAL ('0)
            ) u_state (
                .clock (clock),
                .reset (reset),
                .din   (w_next),
                .dout  (w_state[g]),
                .wen   (w_wen)
            );
        end
    endgenerate

endmodule : replacer
`default_nettype wire

// File: tb/tb_replacer.sv
`default_nettype none
// ============================================================================
// Module      : tb_replacer
// Description : Directed self-checking bench for the replacer victim selector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_replacer;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] idx;
    logic [2:0] way;
    logic       access;
    logic       invalid;
    logic [2:0] rway_o;

    int compared   = 0;
    int mismatched = 0;

    replacer u_dut (
        .clock   (clock),
        .reset   (reset),
        .idx     (idx),
        .way     (way),
        .access  (access),
        .invalid (invalid),
        .rway_o  (rway_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [4:0] set, input logic [2:0] expected);
        idx = set;
        #1;
        compared++;
        assert (rway_o === expected) else begin
            mismatched++;
            $error("FAIL %s idx=%0d: observed %0d expected %0d", tag, set, rway_o, expected);
        end
    endtask

    task automatic do_access(input logic [4:0] set, input logic [2:0] w);
        idx    = set;
        way    = w;
        access = 1'b1;
        @(posedge clock);
        #1;
        access = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        idx     = '0;
        way     = '0;
        access  = 1'b0;
        invalid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int s = 0; s < 32; s++) check("reset_sweep", 5'(s), 3'd0);

        // Set 3: first fill goes to lowest unfilled way, then PLRU once full.
        do_access(5'd3, 3'd0);
        check("fill_way0", 5'd3, 3'd1);
        for (int w = 1; w < 8; w++) do_access(5'd3, 3'(w));
        check("full_plru", 5'd3, 3'd0);
        do_access(5'd3, 3'd0);
        check("touch_way0", 5'd3, 3'd4);
        do_access(5'd3, 3'd0);
        check("idempotent", 5'd3, 3'd4);

        // Evict the victim (way 4), then refill around it.
        idx     = 5'd3;
        invalid = 1'b1;
        @(posedge clock);
        #1;
        invalid = 1'b0;
        check("after_inval", 5'd3, 3'd4);
        do_access(5'd3, 3'd2);
        check("unfilled_prio", 5'd3, 3'd4);
        // Tree now node0=0, node1=0 (from way2), node3=1 (from way0) -> way 1.
        do_access(5'd3, 3'd4);
        check("refill_way4", 5'd3, 3'd1);

        // Set 5 filled completely; neighbours untouched.
        for (int w = 0; w < 8; w++) do_access(5'd5, 3'(w));
        check("set5_full", 5'd5, 3'd0);
        do_access(5'd5, 3'd0);
        check("set5_touch0", 5'd5, 3'd4);
        check("set6_clean", 5'd6, 3'd0);
        check("set3_intact", 5'd3, 3'd1);

        // Set 7: steer the victim to way 2, then access+invalidate it together.
        for (int w = 0; w < 8; w++) do_access(5'd7, 3'(w));
        do_access(5'd7, 3'd0);
        do_access(5'd7, 3'd4);
        check("set7_victim2", 5'd7, 3'd2);
        idx     = 5'd7;
        way     = 3'd2;
        access  = 1'b1;
        invalid = 1'b1;
        @(posedge clock);
        #1;
        access  = 1'b0;
        invalid = 1'b0;
        check("acc_wins", 5'd7, 3'd6);

        // Reset mid-fill of set 3 with strobes asserted.
        do_access(5'd3, 3'd5);
        idx     = 5'd3;
        way     = 3'd6;
        access  = 1'b1;
        invalid = 1'b1;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        access  = 1'b0;
        invalid = 1'b0;
        for (int s = 0; s < 32; s++) check("reset_prio", 5'(s), 3'd0);
        do_access(5'd3, 3'd0);
        check("post_reset_fill", 5'd3, 3'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_replacer
`default_nettype wire
